// File: rtl/mem_port_arbiter.sv
// N-channel arbiter merging cache-side request channels onto one memory port.
// One transaction outstanding at a time, latched at grant and held until mem_resp.
module mem_port_arbiter #(
    parameter int NUM_CH  = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 256,
    parameter int RR_MODE = 0,
    localparam int GW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        ch_read,
    input  logic [NUM_CH-1:0]        ch_write,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
    output logic [DATA_W-1:0]        ch_rdata,
    output logic [NUM_CH-1:0]        ch_resp,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    input  logic                     mem_resp,
    output logic [GW-1:0]            grant_id,
    output logic                     busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [NUM_CH-1:0]   req_s;
    logic                any_req_s;
    logic                found_s;
    logic [GW-1:0]       win_s;
    int                  rr_idx_s;
    logic [GW-1:0]       last_grant_r;
    logic [GW-1:0]       grant_id_r;
    logic                mem_read_r;
    logic                mem_write_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [DATA_W-1:0]   mem_wdata_r;
    logic [DATA_W-1:0]   ch_rdata_r;
    logic [NUM_CH-1:0]   ch_resp_r;
    logic                busy_r;

    // Winner selection: lowest index, or rotating search starting after last grant
    always_comb begin
        req_s     = ch_read | ch_write;
        any_req_s = |req_s;
        found_s   = 1'b0;
        win_s     = '0;
        rr_idx_s  = 0;
        if (RR_MODE != 0) begin
            for (int k = 0; k < NUM_CH; k++) begin
                rr_idx_s = (int'(last_grant_r) + 1 + k) % NUM_CH;
                if (!found_s && req_s[rr_idx_s]) begin
                    found_s = 1'b1;
                    win_s   = GW'(rr_idx_s);
                end else begin
                    found_s = found_s;
                end
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (!found_s && req_s[k]) begin
                    found_s = 1'b1;
                    win_s   = GW'(k);
                end else begin
                    found_s = found_s;
                end
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (any_req_s) state_nxt_s = ISSUE;
                else           state_nxt_s = IDLE;
            end
            ISSUE: begin
                if (mem_resp) state_nxt_s = RESP;
                else          state_nxt_s = ISSUE;
            end
            RESP:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_r <= IDLE;
        else       state_r <= state_nxt_s;
    end

    // Transaction latch, memory strobes and channel-side response registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_r <= GW'(NUM_CH - 1);
            grant_id_r   <= '0;
            mem_read_r   <= 1'b0;
            mem_write_r  <= 1'b0;
            mem_addr_r   <= '0;
            mem_wdata_r  <= '0;
            ch_rdata_r   <= '0;
            ch_resp_r    <= '0;
            busy_r       <= 1'b0;
        end else begin
            ch_resp_r <= '0;
            busy_r    <= (state_nxt_s != IDLE);
            case (state_r)
                IDLE: begin
                    if (any_req_s) begin
                        // A simultaneous read+write on one channel is a write
                        grant_id_r   <= win_s;
                        last_grant_r <= win_s;
                        mem_write_r  <= ch_write[win_s];
                        mem_read_r   <= ~ch_write[win_s];
                        mem_addr_r   <= ch_addr[int'(win_s)*ADDR_W +: ADDR_W];
                        mem_wdata_r  <= ch_wdata[int'(win_s)*DATA_W +: DATA_W];
                    end
                end
                ISSUE: begin
                    if (mem_resp) begin
                        mem_read_r            <= 1'b0;
                        mem_write_r           <= 1'b0;
                        ch_resp_r[grant_id_r] <= 1'b1;
                        if (!mem_write_r) ch_rdata_r <= mem_rdata;
                    end
                end
                RESP: begin
                    mem_read_r  <= 1'b0;
                    mem_write_r <= 1'b0;
                end
                default: begin
                    mem_read_r  <= 1'b0;
                    mem_write_r <= 1'b0;
                end
            endcase
        end
    end

    assign grant_id  = grant_id_r;
    assign mem_read  = mem_read_r;
    assign mem_write = mem_write_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign ch_rdata  = ch_rdata_r;
    assign ch_resp   = ch_resp_r;
    assign busy      = busy_r;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Parametrised N-channel arbiter that merges independent cache-side memory request channels onto the single physical memory port of the pipelined core.
- Generalises the fixed instruction/data port pair to NUM_CH channels with configurable address/data width and selectable fixed-priority or round-robin grant.
- Sits between the L1 caches and main memory.
- One transaction is outstanding at a time; it is latched at grant and held stable until memory responds.

## Interface
Parameters:
- NUM_CH, 2, number of requesting channels (≥2); channel 0 = instruction side, 1 = data side by convention.
- ADDR_W, 32, address width.
- DATA_W, 256, transfer (cache line) width.
- RR_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- ch_read  input  NUM_CH  per-channel read request, level.
- ch_write  input  NUM_CH  per-channel write request, level.
- ch_addr  input  NUM_CH*ADDR_W  flattened addresses; channel i at bits [i*ADDR_W +: ADDR_W].
- ch_wdata  input  NUM_CH*DATA_W  flattened write data, same packing.
- ch_rdata  output  DATA_W  read data, broadcast to all channels.
- ch_resp  output  NUM_CH  one-cycle completion pulse to the granted channel.
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data, valid with mem_resp.
- mem_resp  input  1  memory completion, one cycle.
- grant_id  output  GW = max(1, $clog2(NUM_CH))  index of the channel currently or last granted.
- busy  output  1  high in ISSUE and RESP.

## Operation
States:
- **IDLE**: sample requests. A channel requests if ch_read[i] | ch_write[i]. If any channel requests, pick a winner and latch its index, op, addr and wdata; go to ISSUE.
- **ISSUE**: drive mem_read/mem_write, mem_addr and mem_wdata from latched registers only. On mem_resp, capture mem_rdata into ch_rdata and go to RESP.
- **RESP**: assert ch_resp[grant_id] for exactly this cycle. Ignore all requests. Go to IDLE.

Arbitration:
- Fixed mode: lowest requesting index wins.
- Round-robin mode: search starts at (last_grant+1) mod NUM_CH and wraps. last_grant updates at latch time.
- Non-power-of-2 NUM_CH: the search wraps at NUM_CH, not at 2^GW.

Request handling:
- ch_read and ch_write both high on one channel: treated as a write.
- Requests are not acknowledged except via ch_resp. Channels must hold their request until ch_resp, and drop it, or present a new one, the cycle after.
- Changes on request inputs during ISSUE/RESP have no effect on the outstanding transaction.

Outputs:
- mem_read/mem_write are registered. Exactly one is high throughout ISSUE; both are low in IDLE and RESP.
- ch_rdata holds its last captured value until the next read completes. It is not updated on writes.

## Timing
Reset values (asynchronous; take effect immediately):
- State = IDLE; mem_read = mem_write = 0; mem_addr = mem_wdata = 0; ch_rdata = 0; ch_resp = 0; busy = 0; grant_id = 0.
- last_grant = NUM_CH-1, so channel 0 is first in round-robin.

Transaction timing:
- Request high at edge T (in IDLE) → mem_read/mem_write high from T+1.
- mem_resp sampled at edge T+k → strobes low and ch_resp high from T+k+1 for one cycle.
- IDLE again at T+k+2.
- Minimum grant-to-grant spacing is 3 cycles when mem_resp arrives in the first ISSUE cycle.
- mem_resp in IDLE or RESP is ignored.

Reset mid-transaction:
- Strobes drop asynchronously and no ch_resp is issued.
- The requesting channel must re-request after reset deasserts.

Fairness:
- In round-robin mode, a continuously requesting channel is granted within NUM_CH grants.
- In fixed mode, starvation of high indices is permitted.

## Test plan
- **Reset:** assert reset mid-ISSUE with mem_read high → mem_read = 0 and state IDLE in the same cycle, no ch_resp; after release, channel 0 read of 0x100 → mem_read at +1.
- **Single read:** ch_read[1] = 1, addr 0x0000_2040; mem_resp at 3rd ISSUE cycle with rdata 0xA5..A5 → mem_addr 0x2040 for 3 cycles, ch_resp = 2'b10 for one cycle, ch_rdata = 0xA5..A5, grant_id = 1.
- **Fixed-priority collision (RR_MODE=0):** ch0 read and ch1 write both held continuously → ch0 granted each time until ch0 drops; ch1 write then issues with ch1 wdata.
- **Round-robin (RR_MODE=1, NUM_CH=3):** all three request continuously → grant order 0,1,2,0,1,2 across six transactions.
- **Read+write same channel:** ch_read[0] = ch_write[0] = 1 → mem_write = 1, mem_read = 0; ch_rdata unchanged after completion.
- **Request churn:** ch2 changes addr from 0x40 to 0x80 during ISSUE → mem_addr stays 0x40 until mem_resp; stray mem_resp during RESP → no extra ch_resp.
